// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: state codes, opcodes
// and the ALU / PC source select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RCOMPL  = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Dispatch target out of DECODE for a given opcode.
    function automatic state_t decode_next(input logic [5:0] op);
        case (op)
            OP_RTYPE:     return S_EXEC;
            OP_LW, OP_SW: return S_MEMADR;
            OP_BEQ:       return S_BRANCH;
            OP_J:         return S_JUMP;
            OP_ADDI:      return S_ADDIEX;
            default:      return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: registered state, combinational Moore decode
// (plus MemReady in FETCH and Zero for PCEn).
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       PCEn,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t state_reg;
    state_t state_next;

    logic mem_ready;
    logic pc_write_dec;
    logic pc_write_cond_dec;
    logic mem_write_dec;
    logic ir_write_dec;
    logic reg_write_dec;
    logic illegal_dec;

    assign mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next        = S_FETCH;
        pc_write_dec      = 1'b0;
        pc_write_cond_dec = 1'b0;
        mem_write_dec     = 1'b0;
        ir_write_dec      = 1'b0;
        reg_write_dec     = 1'b0;
        illegal_dec       = 1'b0;
        IorD              = 1'b0;
        MemRead           = 1'b0;
        MemtoReg          = 1'b0;
        ALUSrcA           = 1'b0;
        RegDst            = 1'b0;
        ALUOp             = ALUOP_ADD;
        ALUSrcB           = SRCB_REG;
        PCSource          = PCSRC_ALU;

        case (state_reg)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write_dec = 1'b1;
                    pc_write_dec = 1'b1;
                    state_next   = S_DECODE;
                end else begin
                    state_next   = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                state_next = decode_next(Opcode);
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write_dec = 1'b1;
                MemtoReg      = 1'b1;
            end
            S_MEMWR: begin
                mem_write_dec = 1'b1;
                IorD          = 1'b1;
                state_next    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_FUNCT;
                state_next = S_RCOMPL;
            end
            S_RCOMPL: begin
                reg_write_dec = 1'b1;
                RegDst        = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA           = 1'b1;
                ALUOp             = ALUOP_SUB;
                pc_write_cond_dec = 1'b1;
                PCSource          = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write_dec = 1'b1;
                PCSource     = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_dec = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_dec = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Write strobes are gated by rst_n so they drop immediately on reset,
    // even though FETCH would otherwise raise them when MemReady is high.
    assign PCWrite     = pc_write_dec & rst_n;
    assign PCWriteCond = pc_write_cond_dec & rst_n;
    assign MemWrite    = mem_write_dec & rst_n;
    assign IRWrite     = ir_write_dec & rst_n;
    assign RegWrite    = reg_write_dec & rst_n;
    assign Illegal     = illegal_dec & rst_n;
    assign PCEn        = PCWrite | (PCWriteCond & Zero);
    assign State       = state_reg;

endmodule
